harmonic_sequencer: RTL
=======================

# harmonic_sequencer

- Parametrised sample-rate sequencer for the additive oscillator.
- Steps a harmonic index through the sample-position lookup, the per-channel harmonic scalers and a bank of NUM_CHANNELS accumulating adders. Harmonic h is routed to channel h mod NUM_CHANNELS.
- Latches the per-channel totals and triggers the DAC output stage on a free-running sample tick.
- Generalises the fixed two-adder odd/even sequencing: channel count, harmonic width, accumulator width and sample interval are parameters. Adds overrun handling when a calculation misses its tick.

## Interface
Parameters:
- NUM_CHANNELS, 2, adder/scaler channels; power of two, 1..8
- HARM_W, 8, harmonic index width
- MAX_HARMONICS, 128, hard ceiling on harmonics per sample
- ACC_W, 32, adder total width (signed)
- SAMPLE_INTERVAL, 1023, tick period minus one, in clocks

Ports:
- i_Clock  in  1  main clock (48 MHz PLL output)
- i_Reset  in  1  synchronous, active-high reset
- i_Harmonic_Count  in  HARM_W  last harmonic index to generate
- i_Freq_Too_High  in  1  sample-position flag: current harmonic above Nyquist
- i_Sample_Ready  in  1  sample value for o_Harmonic valid
- o_Harmonic  out  HARM_W  harmonic index to sample-position block
- o_Next_Sample  out  1  one-cycle request for next lookup
- o_Scaler_Start  out  NUM_CHANNELS  one-hot, one-cycle scaler step
- i_Scaler_Ready  in  NUM_CHANNELS  scaler multiplier valid
- o_Scaler_Restart  out  1  one-cycle scaler reload to initial value
- o_Adder_Start  out  NUM_CHANNELS  one-hot, one-cycle accumulate strobe
- o_Adder_Clear  out  1  one-cycle accumulator clear
- i_Adder_Total  in  NUM_CHANNELS*ACC_W  packed adder totals; channel c at [c*ACC_W +: ACC_W]
- o_Total  out  NUM_CHANNELS*ACC_W  latched totals to Sample_Output
- o_DAC_Send  out  1  one-cycle DAC start
- o_Overrun  out  1  one-cycle pulse: tick arrived mid-calculation

## Operation
- ch = o_Harmonic[log2(NUM_CHANNELS)-1:0]. With NUM_CHANNELS=1, ch=0.
- Timer counts 0..SAMPLE_INTERVAL, then wraps to 0. It is free-running and never reloaded by the FSM. tick = (timer == SAMPLE_INTERVAL).
- INIT: go to ADD_START. Harmonic 0 skips scaling and uses the scaler initial value.
- SCALE_START: o_Scaler_Start[ch]=1, then SCALE_WAIT.
- SCALE_WAIT: wait for i_Scaler_Ready[ch], then ADD_START.
- ADD_START: on i_Sample_Ready, o_Adder_Start[ch]=1, then NEXT.
- NEXT:
  - If o_Harmonic >= i_Harmonic_Count, or i_Freq_Too_High, or o_Harmonic == MAX_HARMONICS-1: go to CALC_DONE.
  - Otherwise: o_Harmonic+1, o_Next_Sample=1, then SCALE_START.
- CALC_DONE: o_Total <= i_Adder_Total, o_Adder_Clear=1, then WAIT_TICK.
- WAIT_TICK: on tick, o_DAC_Send=1, o_Scaler_Restart=1, o_Next_Sample=1, o_Harmonic=0, then INIT.
- Overrun (tick in any state other than WAIT_TICK):
  - Abort the calculation; o_Total keeps its previous value.
  - o_Overrun=1, o_DAC_Send=1, o_Adder_Clear=1, o_Scaler_Restart=1, o_Next_Sample=1, o_Harmonic=0, then INIT.
- i_Harmonic_Count and i_Freq_Too_High are sampled only in NEXT.
- All strobes are registered, one-hot per channel, and never asserted for more than one cycle.

## Timing
- Reset values: every output 0, timer 0, FSM in INIT.
- Reset mid-calculation drops all pulses on the next edge; no DAC_Send is issued.
- Scaler start to adder start: at least 2 cycles (SCALE_WAIT observes ready no earlier than the cycle after the start strobe).
- Minimum per harmonic: 4 cycles (SCALE_START, SCALE_WAIT, ADD_START, NEXT) when ready signals are already high.
- DAC_Send goes high the cycle after tick is seen; DAC_Send period is exactly SAMPLE_INTERVAL+1 cycles.
- o_Total is stable from CALC_DONE+1 until the next CALC_DONE.
- Tick arriving in the same cycle as CALC_DONE is treated as an overrun; the totals are not latched.

## Configuration
- HARMONIC_SEQ_OVERRUN_CNT_EN defined:
  - Adds output o_Overrun_Count [15:0]: saturating count of overruns, cleared by reset.
  - Adds input i_Overrun_Clear: synchronous count clear; clear wins over a simultaneous increment.
- Not defined: ports absent; o_Overrun behaviour unchanged.

## Structure
- Package harmonic_seq_pkg holds:
  - the FSM state enum: INIT, SCALE_START, SCALE_WAIT, ADD_START, NEXT, CALC_DONE, WAIT_TICK
  - function ch_bits(NUM_CHANNELS)
  - the default SAMPLE_INTERVAL constant.
- One sub-module, sample_rate_timer: counter plus registered tick, parameter INTERVAL.

## Test plan
- NUM_CHANNELS=2, SAMPLE_INTERVAL=63, count=5, ready inputs always high:
  - harmonics 0..5 dispatched
  - o_Adder_Start pattern 01,10,01,10,01,10
  - 5 scaler starts
  - DAC_Send every 64 cycles.
- NUM_CHANNELS=4, count=7:
  - each channel gets exactly 2 adder starts per sample
  - o_Total equals the driven i_Adder_Total values captured at CALC_DONE.
- i_Freq_Too_High asserted at harmonic 3, count=20 -> CALC_DONE after harmonic 3; 4 adder starts.
- count=255, MAX_HARMONICS=128, SAMPLE_INTERVAL=1023 -> stops at harmonic 127; no overrun.
- SAMPLE_INTERVAL=15, count=10 -> overrun:
  - o_Overrun pulses every 16 cycles
  - o_Total stays at its reset value 0
  - with the macro, the counter increments each overrun.
- Reset asserted during ADD_START -> next cycle all outputs 0; first DAC_Send SAMPLE_INTERVAL+1 cycles after release.

Source files
------------

// File: rtl/harmonic_seq_pkg.sv
// Shared types and helpers for the harmonic sequencer.
// Optional overrun counter: HARMONIC_SEQ_OVERRUN_CNT_EN.
package harmonic_seq_pkg;

  localparam int DEFAULT_SAMPLE_INTERVAL = 1023;

  typedef enum logic [2:0] {
    INIT,
    SCALE_START,
    SCALE_WAIT,
    ADD_START,
    NEXT,
    CALC_DONE,
    WAIT_TICK
  } state_t;

  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/harmonic_sequencer_if.sv
// Handshake bundle between the sequencer and its oscillator datapath.
// Optional overrun counter: HARMONIC_SEQ_OVERRUN_CNT_EN.
interface harmonic_sequencer_if #(
  parameter int NUM_CHANNELS = 2,
  parameter int HARM_W       = 8,
  parameter int ACC_W        = 32
);

  logic [HARM_W-1:0]             i_Harmonic_Count;
  logic                          i_Freq_Too_High;
  logic                          i_Sample_Ready;
  logic [HARM_W-1:0]             o_Harmonic;
  logic                          o_Next_Sample;
  logic [NUM_CHANNELS-1:0]       o_Scaler_Start;
  logic [NUM_CHANNELS-1:0]       i_Scaler_Ready;
  logic                          o_Scaler_Restart;
  logic [NUM_CHANNELS-1:0]       o_Adder_Start;
  logic                          o_Adder_Clear;
  logic [NUM_CHANNELS*ACC_W-1:0] i_Adder_Total;
  logic [NUM_CHANNELS*ACC_W-1:0] o_Total;
  logic                          o_DAC_Send;
  logic                          o_Overrun;
`ifdef HARMONIC_SEQ_OVERRUN_CNT_EN
  logic [15:0]                   o_Overrun_Count;
  logic                          i_Overrun_Clear;
`endif

  modport master (
`ifdef HARMONIC_SEQ_OVERRUN_CNT_EN
    output o_Overrun_Count,
    input  i_Overrun_Clear,
`endif
    input  i_Harmonic_Count,
    input  i_Freq_Too_High,
    input  i_Sample_Ready,
    input  i_Scaler_Ready,
    input  i_Adder_Total,
    output o_Harmonic,
    output o_Next_Sample,
    output o_Scaler_Start,
    output o_Scaler_Restart,
    output o_Adder_Start,
    output o_Adder_Clear,
    output o_Total,
    output o_DAC_Send,
    output o_Overrun
  );

  modport slave (
`ifdef HARMONIC_SEQ_OVERRUN_CNT_EN
    input  o_Overrun_Count,
    output i_Overrun_Clear,
`endif
    output i_Harmonic_Count,
    output i_Freq_Too_High,
    output i_Sample_Ready,
    output i_Scaler_Ready,
    output i_Adder_Total,
    input  o_Harmonic,
    input  o_Next_Sample,
    input  o_Scaler_Start,
    input  o_Scaler_Restart,
    input  o_Adder_Start,
    input  o_Adder_Clear,
    input  o_Total,
    input  o_DAC_Send,
    input  o_Overrun
  );

endinterface

// File: rtl/sample_rate_timer.sv
// Free-running sample counter; tick is high while count == INTERVAL.
// Optional overrun counter elsewhere: HARMONIC_SEQ_OVERRUN_CNT_EN.
module sample_rate_timer #(
  parameter int INTERVAL = 1023
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;

  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;

  assign count_nx = (count == CW'(INTERVAL)) ? '0 : count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= count_nx;
      tick  <= (count_nx == CW'(INTERVAL));
    end
  end

endmodule

// File: rtl/harmonic_sequencer.sv
// Harmonic sequencer: walks harmonics through scalers/adders per sample tick.
// Optional overrun counter: HARMONIC_SEQ_OVERRUN_CNT_EN.
module harmonic_sequencer
  import harmonic_seq_pkg::*;
#(
  parameter int NUM_CHANNELS    = 2,
  parameter int HARM_W          = 8,
  parameter int MAX_HARMONICS   = 128,
  parameter int ACC_W           = 32,
  parameter int SAMPLE_INTERVAL = DEFAULT_SAMPLE_INTERVAL
) (
  input logic                  i_Clock,
  input logic                  i_Reset,
  harmonic_sequencer_if.master bus
);

  localparam int CB = ch_bits(NUM_CHANNELS);
  localparam int TW = NUM_CHANNELS * ACC_W;
  localparam logic [HARM_W-1:0] HARM_LAST =
    HARM_W'(MAX_HARMONICS - 1);

  state_t                  state;
  logic [HARM_W-1:0]       harm;
  logic                    next_sample;
  logic [NUM_CHANNELS-1:0] scaler_start;
  logic                    scaler_restart;
  logic [NUM_CHANNELS-1:0] adder_start;
  logic                    adder_clear;
  logic [TW-1:0]           total;
  logic                    dac_send;
  logic                    overrun;

  logic                    tick;
  logic                    ovr_hit;
  logic                    last;
  logic [CB-1:0]           ch;
  logic [NUM_CHANNELS-1:0] ch_hot;

  sample_rate_timer #(
    .INTERVAL(SAMPLE_INTERVAL)
  ) u_timer (
    .clk  (i_Clock),
    .rst  (i_Reset),
    .tick (tick)
  );

  if (NUM_CHANNELS == 1) begin : g_one
    assign ch = '0;
  end else begin : g_many
    assign ch = harm[CB-1:0];
  end

  assign ch_hot  = NUM_CHANNELS'(1) << ch;
  assign ovr_hit = tick && (state != WAIT_TICK);
  assign last    = (harm >= bus.i_Harmonic_Count)
                || bus.i_Freq_Too_High
                || (harm == HARM_LAST);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state          <= INIT;
      harm           <= '0;
      next_sample    <= 1'b0;
      scaler_start   <= '0;
      scaler_restart <= 1'b0;
      adder_start    <= '0;
      adder_clear    <= 1'b0;
      total          <= '0;
      dac_send       <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      next_sample    <= 1'b0;
      scaler_start   <= '0;
      scaler_restart <= 1'b0;
      adder_start    <= '0;
      adder_clear    <= 1'b0;
      dac_send       <= 1'b0;
      overrun        <= 1'b0;
      // A tick outside WAIT_TICK aborts the sample; o_Total is kept.
      if (ovr_hit) begin
        overrun        <= 1'b1;
        dac_send       <= 1'b1;
        adder_clear    <= 1'b1;
        scaler_restart <= 1'b1;
        next_sample    <= 1'b1;
        harm           <= '0;
        state          <= INIT;
      end else begin
        unique case (state)
          INIT: state <= ADD_START;
          SCALE_START: begin
            scaler_start <= ch_hot;
            state        <= SCALE_WAIT;
          end
          SCALE_WAIT: begin
            if (|(bus.i_Scaler_Ready & ch_hot))
              state <= ADD_START;
          end
          ADD_START: begin
            if (bus.i_Sample_Ready) begin
              adder_start <= ch_hot;
              state       <= NEXT;
            end
          end
          NEXT: begin
            if (last) begin
              state <= CALC_DONE;
            end else begin
              harm        <= harm + 1'b1;
              next_sample <= 1'b1;
              state       <= SCALE_START;
            end
          end
          CALC_DONE: begin
            total       <= bus.i_Adder_Total;
            adder_clear <= 1'b1;
            state       <= WAIT_TICK;
          end
          WAIT_TICK: begin
            if (tick) begin
              dac_send       <= 1'b1;
              scaler_restart <= 1'b1;
              next_sample    <= 1'b1;
              harm           <= '0;
              state          <= INIT;
            end
          end
          default: state <= INIT;
        endcase
      end
    end
  end

  assign bus.o_Harmonic       = harm;
  assign bus.o_Next_Sample    = next_sample;
  assign bus.o_Scaler_Start   = scaler_start;
  assign bus.o_Scaler_Restart = scaler_restart;
  assign bus.o_Adder_Start    = adder_start;
  assign bus.o_Adder_Clear    = adder_clear;
  assign bus.o_Total          = total;
  assign bus.o_DAC_Send       = dac_send;
  assign bus.o_Overrun        = overrun;

`ifdef HARMONIC_SEQ_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || bus.i_Overrun_Clear)
      ovr_cnt <= '0;
    else if (ovr_hit && (ovr_cnt != 16'hFFFF))
      ovr_cnt <= ovr_cnt + 16'd1;
  end

  assign bus.o_Overrun_Count = ovr_cnt;
`endif

endmodule
